proc_run_ctrl: RTL
==================

Name: proc_run_ctrl

Overview:
- Run/halt/single-step sequencer for the single-cycle processor datapath.
- Generates a per-cycle enable `cpuEn`. Top level ANDs it into the PC update (InstrFetch), the register-file write enable and the data-memory write enable, so a disabled cycle leaves all architectural state unchanged.
- Supports free run, N-instruction stepping, a PC breakpoint, halt-cause reporting and a retired-instruction counter for the I/O debug path.

Parameters:
- DBITS, 32, datapath/PC width and retired-counter width.
- STEP_BITS, 8, width of the step-count request and of the internal remaining-step counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- runReq  input  1  one-cycle pulse: enter free run.
- stepReq  input  1  one-cycle pulse: execute stepCount instructions, then halt.
- haltReq  input  1  one-cycle pulse: stop immediately.
- stepCount  input  STEP_BITS  number of instructions per step request; sampled when stepReq is accepted.
- brkEn  input  1  breakpoint enable.
- brkAddr  input  DBITS  breakpoint PC (byte address).
- pcOut  input  DBITS  current PC from InstrFetch.
- cpuEn  output  1  combinational; 1 = the instruction at pcOut executes/commits this cycle.
- halted  output  1  registered; 1 when state is HALT.
- haltCause  output  2  registered; 00 reset, 01 haltReq, 10 step done, 11 breakpoint.
- retired  output  DBITS  registered count of enabled cycles; wraps modulo 2^DBITS.

Behaviour:
- States: HALT, RUN, STEP.
- Reset: state=HALT, halted=1, haltCause=00, retired=0, stepsLeft=0, skipBrk=0. cpuEn=0 while in HALT. Reset overrides every request, including mid-RUN or mid-STEP.
- Request priority in any state: haltReq > stepReq > runReq.
- brkMatch = brkEn && (pcOut == brkAddr) && !skipBrk.
- cpuEn = (state==RUN || state==STEP) && !brkMatch && !haltReq. Zero latency: a haltReq cycle commits nothing.
- retired increments by 1 on every cycle with cpuEn=1.

HALT:
- haltReq: stay in HALT, haltCause=01.
- stepReq with stepCount!=0: go to STEP, stepsLeft=stepCount, skipBrk=1.
- stepReq with stepCount==0: ignored; no state or cause change.
- runReq: go to RUN, skipBrk=1.
- Other requests (runReq/stepReq) while in RUN or STEP are ignored.

skipBrk:
- Cleared at the end of the first cycle spent in RUN or STEP, whatever cpuEn was in that cycle.
- Guarantees a resume from a breakpoint executes the instruction at brkAddr.

RUN:
- haltReq: go to HALT, haltCause=01.
- Else brkMatch: go to HALT, haltCause=11. The instruction at brkAddr is not executed; pcOut stays at brkAddr.

STEP:
- haltReq: go to HALT, haltCause=01, stepsLeft=0.
- Else brkMatch: go to HALT, haltCause=11, stepsLeft=0.
- Else cpuEn=1: stepsLeft decrements. If stepsLeft was 1, go to HALT, haltCause=10.
- Exactly stepCount instructions commit when no halt or breakpoint intervenes.

halted is 0 in RUN/STEP. It rises on the clock edge that enters HALT, the same edge on which haltCause updates.

Test Plan:
- Reset held 2 cycles with runReq=1 -> halted=1, haltCause=00, cpuEn=0, retired=0; pcOut stays 0x40.
- HALT, stepReq with stepCount=3, brkEn=0 -> cpuEn=1 for exactly 3 cycles; retired=3; halted=1 on the 4th edge; haltCause=10; pcOut advanced 0x40->0x4C.
- runReq, brkEn=1, brkAddr=0x54 -> cpuEn=0 in the cycle pcOut=0x54; halted=1; haltCause=11; retired=5. A second runReq then executes 0x54 (skipBrk) and continues to 0x58.
- RUN, then haltReq at cycle k -> cpuEn=0 in cycle k; halted=1 next edge; haltCause=01; retired=k-1 counted from the run start.
- HALT with haltReq+runReq in the same cycle -> stays HALT, haltCause=01. stepReq with stepCount=0 -> no change, cpuEn stays 0.
- STEP with stepCount=255 and reset asserted mid-sequence -> next edge: HALT, haltCause=00, retired=0. Force retired=0xFFFFFFFF and run 1 step -> retired=0.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// Run/halt/single-step sequencer: produces the per-cycle commit enable for the
// single-cycle datapath, handles N-instruction stepping, a PC breakpoint,
// halt-cause reporting and a retired-instruction counter.
module proc_run_ctrl #(
    parameter int DBITS     = 32,
    parameter int STEP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 runReq,
    input  logic                 stepReq,
    input  logic                 haltReq,
    input  logic [STEP_BITS-1:0] stepCount,
    input  logic                 brkEn,
    input  logic [DBITS-1:0]     brkAddr,
    input  logic [DBITS-1:0]     pcOut,
    output logic                 cpuEn,
    output logic                 halted,
    output logic [1:0]           haltCause,
    output logic [DBITS-1:0]     retired
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_RESET = 2'b00;
    localparam logic [1:0] CAUSE_HALT  = 2'b01;
    localparam logic [1:0] CAUSE_STEP  = 2'b10;
    localparam logic [1:0] CAUSE_BRK   = 2'b11;

    state_t               state_q, state_d;
    logic [STEP_BITS-1:0] steps_left_q, steps_left_d;
    logic                 skip_brk_q, skip_brk_d;
    logic                 halted_q, halted_d;
    logic [1:0]           halt_cause_q, halt_cause_d;
    logic [DBITS-1:0]     retired_q, retired_d;

    logic                 brk_match;
    logic                 active;

    // skip_brk masks the breakpoint for the first cycle after a resume so the
    // instruction sitting at brkAddr gets executed instead of re-trapping.
    assign brk_match = brkEn && (pcOut == brkAddr) && !skip_brk_q;
    assign active    = (state_q == S_RUN) || (state_q == S_STEP);
    assign cpuEn     = active && !brk_match && !haltReq;

    assign halted    = halted_q;
    assign haltCause = halt_cause_q;
    assign retired   = retired_q;

    // Next-state, step counter, cause and retired-count logic.
    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        skip_brk_d   = skip_brk_q;
        halt_cause_d = halt_cause_q;
        retired_d    = retired_q + DBITS'(cpuEn);

        case (state_q)
            S_HALT: begin
                if (haltReq) begin
                    halt_cause_d = CAUSE_HALT;
                end else if (stepReq) begin
                    // A zero-length step request is dropped entirely.
                    if (stepCount != '0) begin
                        state_d      = S_STEP;
                        steps_left_d = stepCount;
                        skip_brk_d   = 1'b1;
                    end
                end else if (runReq) begin
                    state_d    = S_RUN;
                    skip_brk_d = 1'b1;
                end
            end
            S_RUN: begin
                skip_brk_d = 1'b0;
                if (haltReq) begin
                    state_d      = S_HALT;
                    halt_cause_d = CAUSE_HALT;
                end else if (brk_match) begin
                    state_d      = S_HALT;
                    halt_cause_d = CAUSE_BRK;
                end
            end
            S_STEP: begin
                skip_brk_d = 1'b0;
                if (haltReq) begin
                    state_d      = S_HALT;
                    halt_cause_d = CAUSE_HALT;
                    steps_left_d = '0;
                end else if (brk_match) begin
                    state_d      = S_HALT;
                    halt_cause_d = CAUSE_BRK;
                    steps_left_d = '0;
                end else begin
                    steps_left_d = steps_left_q - STEP_BITS'(1);
                    if (steps_left_q == STEP_BITS'(1)) begin
                        state_d      = S_HALT;
                        halt_cause_d = CAUSE_STEP;
                    end
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        halted_d = (state_d == S_HALT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_HALT;
            steps_left_q <= '0;
            skip_brk_q   <= 1'b0;
            halted_q     <= 1'b1;
            halt_cause_q <= CAUSE_RESET;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            skip_brk_q   <= skip_brk_d;
            halted_q     <= halted_d;
            halt_cause_q <= halt_cause_d;
            retired_q    <= retired_d;
        end
    end

endmodule
